mem_read_tile_gen: RTL and testbench

//  Parametrised read-address generator for the D operand of the matrix-multiply datapath.
//  - Walks a row-major matrix tile by tile and emits one read address per accepted beat.
//  - Drives a one-hot row-activate vector that steers each word into its systolic-array row.
//  - Adds run-time matrix size and base address, selectable element order,

---
 rtl/mem_read_tile_gen.sv | 167 ++++++++++++++++
 tb/tb_mem_read_tile_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_read_tile_gen.sv
// Read-address generator for the D operand: walks a row-major matrix tile by tile,
// emitting one address per accepted beat with a one-hot row-activate vector.
module mem_read_tile_gen #(
  parameter int unsigned N1           = 4,
  parameter int unsigned N2           = 4,
  parameter int unsigned MATRIXSIZE_W = 16,
  parameter int unsigned ADDR_W       = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       cfg_base,
  input  logic [MATRIXSIZE_W-1:0] cfg_rows,
  input  logic [MATRIXSIZE_W-1:0] cfg_cols,
  input  logic                    cfg_desc,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [N1-1:0]           activate,
  output logic                    tile_last
);

  localparam int unsigned LogN1 = $clog2(N1);
  localparam int unsigned LogN2 = $clog2(N2);
  localparam int unsigned IW    = (N1 > 1) ? LogN1 : 1;
  localparam int unsigned KW    = (N2 > 1) ? LogN2 : 1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e                  state_q;
  logic                    busy_q, done_q, cfg_err_q, rd_valid_q, tile_last_q, desc_q;
  logic [ADDR_W-1:0]       rd_addr_q, cols_q, row_base_q, tile_base_q;
  logic [N1-1:0]           activate_q;
  logic [MATRIXSIZE_W-1:0] g_q, t_q, g_max_q, t_max_q;
  logic [IW-1:0]           i_q;
  logic [KW-1:0]           k_q;

  logic              cfg_bad, accept, k_last, i_last, t_last, g_last;
  logic [IW-1:0]     i_inc;
  logic [KW-1:0]     k_inc;
  logic [ADDR_W-1:0] koff_start, koff_run, next_row, next_tile;

  always_comb begin
    cfg_bad = (cfg_rows == '0) || (cfg_cols == '0) ||
              ((cfg_rows & MATRIXSIZE_W'(N1 - 1)) != '0) ||
              ((cfg_cols & MATRIXSIZE_W'(N2 - 1)) != '0);
    accept     = rd_valid_q && rd_ready;
    k_last     = (k_q == KW'(N2 - 1));
    i_last     = (i_q == IW'(N1 - 1));
    t_last     = (t_q == t_max_q);
    g_last     = (g_q == g_max_q);
    i_inc      = i_q + IW'(1);
    k_inc      = k_q + KW'(1);
    // Offset of the first element of a row segment depends on walk direction.
    koff_start = cfg_desc ? ADDR_W'(N2 - 1) : '0;
    koff_run   = desc_q ? ADDR_W'(N2 - 1) : '0;
    next_row   = row_base_q + cols_q;
    // Advancing past the last row's final tile lands exactly on the next group's row 0.
    next_tile  = (i_last && t_last) ? row_base_q + ADDR_W'(N2) : tile_base_q + ADDR_W'(N2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      tile_last_q <= 1'b0;
      desc_q      <= 1'b0;
      rd_addr_q   <= '0;
      cols_q      <= '0;
      row_base_q  <= '0;
      tile_base_q <= '0;
      activate_q  <= '0;
      g_q         <= '0;
      t_q         <= '0;
      g_max_q     <= '0;
      t_max_q     <= '0;
      i_q         <= '0;
      k_q         <= '0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !done_q) begin
            if (cfg_bad) begin
              done_q    <= 1'b1;
              cfg_err_q <= 1'b1;
            end else begin
              cols_q      <= ADDR_W'(cfg_cols);
              desc_q      <= cfg_desc;
              g_max_q     <= (cfg_rows >> LogN1) - MATRIXSIZE_W'(1);
              t_max_q     <= (cfg_cols >> LogN2) - MATRIXSIZE_W'(1);
              row_base_q  <= cfg_base;
              tile_base_q <= cfg_base;
              rd_addr_q   <= cfg_base + koff_start;
              g_q         <= '0;
              t_q         <= '0;
              i_q         <= '0;
              k_q         <= '0;
              activate_q  <= N1'(1);
              tile_last_q <= (N2 == 1);
              rd_valid_q  <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= StRun;
            end
          end
        end
        StRun: begin
          if (accept) begin
            if (!k_last) begin
              k_q         <= k_inc;
              rd_addr_q   <= desc_q ? rd_addr_q - ADDR_W'(1) : rd_addr_q + ADDR_W'(1);
              tile_last_q <= (k_inc == KW'(N2 - 1));
            end else begin
              k_q         <= '0;
              tile_last_q <= (N2 == 1);
              if (!i_last) begin
                i_q        <= i_inc;
                row_base_q <= next_row;
                rd_addr_q  <= next_row + koff_run;
                activate_q <= N1'(1) << i_inc;
              end else if (!t_last || !g_last) begin
                i_q         <= '0;
                activate_q  <= N1'(1);
                tile_base_q <= next_tile;
                row_base_q  <= next_tile;
                rd_addr_q   <= next_tile + koff_run;
                if (!t_last) begin
                  t_q <= t_q + MATRIXSIZE_W'(1);
                end else begin
                  t_q <= '0;
                  g_q <= g_q + MATRIXSIZE_W'(1);
                end
              end else begin
                i_q         <= '0;
                t_q         <= '0;
                g_q         <= '0;
                activate_q  <= '0;
                tile_last_q <= 1'b0;
                rd_valid_q  <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                state_q     <= StIdle;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign rd_addr   = rd_addr_q;
  assign rd_valid  = rd_valid_q;
  assign activate  = activate_q;
  assign tile_last = tile_last_q;

endmodule

// File: tb/tb_mem_read_tile_gen.sv
// Directed bench for mem_read_tile_gen: table of passes checked beat-by-beat against
// a direct-formula address model, plus hand-written reset and wrap sequences.
module tb_mem_read_tile_gen;

  logic        clk = 1'b0;
  logic        rst_n, start, cfg_desc, rd_ready;
  logic [11:0] cfg_base;
  logic [15:0] cfg_rows, cfg_cols;
  logic        busy, done, cfg_err, rd_valid, tile_last;
  logic [11:0] rd_addr;
  logic [3:0]  activate;

  int checks = 0;
  int errors = 0;
  logic [11:0] cap[$];

  typedef struct {
    int base;
    int rows;
    int cols;
    int desc;
    int mode;   // 0: ready=1, 1: ready 1,0,0,1, 2: random ready with start held high
    int err;
    int first;
  } vec_t;

  vec_t tbl[10];

  mem_read_tile_gen #(
    .N1(4), .N2(4), .MATRIXSIZE_W(16), .ADDR_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_base(cfg_base), .cfg_rows(cfg_rows),
    .cfg_cols(cfg_cols), .cfg_desc(cfg_desc), .busy(busy), .done(done), .cfg_err(cfg_err),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready), .activate(activate),
    .tile_last(tile_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_pass(input int base, input int rows, input int cols, input int desc,
                          input int mode, input int err, input int first);
    logic [11:0] ea[$];
    logic [3:0]  eact[$];
    logic        elast[$];
    int beat, cyc, a;
    logic rdy;
    if (err == 0) begin
      for (int g = 0; g < rows / 4; g++)
        for (int t = 0; t < cols / 4; t++)
          for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
              a = base + (g * 4 + i) * cols + t * 4 + ((desc != 0) ? 3 - k : k);
              ea.push_back(a[11:0]);
              eact.push_back(4'(1 << i));
              elast.push_back(k == 3);
            end
    end
    cap.delete();
    @(posedge clk); #1;
    start = 1'b1; cfg_base = 12'(base); cfg_rows = 16'(rows); cfg_cols = 16'(cols);
    cfg_desc = (desc != 0); rd_ready = (mode == 0);
    @(posedge clk); #1;
    if (mode != 2) start = 1'b0;
    cfg_base = 12'($urandom); cfg_rows = 16'($urandom); cfg_cols = 16'($urandom);
    cfg_desc = 1'($urandom);
    if (err != 0) begin
      chk("err_pulse", {60'd0, done, cfg_err, rd_valid, busy}, 64'b1100);
      @(posedge clk); #1;
      chk("err_after", {61'd0, done, rd_valid, busy}, 64'd0);
      return;
    end
    beat = 0;
    cyc = 0;
    while (beat < ea.size() && cyc < 2000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rd_ready = rdy;
      chk("beat", {45'd0, rd_valid, busy, rd_addr, activate, tile_last},
          {45'd0, 1'b1, 1'b1, ea[beat], eact[beat], elast[beat]});
      if (rdy) begin
        cap.push_back(rd_addr);
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 2000) chk("timeout", 64'(beat), 64'(ea.size()));
    rd_ready = 1'b0;
    chk("beat_count", 64'(beat), 64'(rows * cols));
    chk("first_addr", 64'(cap[0]), 64'(first));
    chk("done_pulse", {58'd0, rd_valid, busy, done, cfg_err, tile_last, |activate},
        {58'd0, 6'b001000});
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_after", {61'd0, done, rd_valid, busy}, 64'd0);
  endtask

  initial begin
    tbl[0] = '{base: 0,    rows: 4, cols: 4,  desc: 1, mode: 0, err: 0, first: 3};
    tbl[1] = '{base: 100,  rows: 4, cols: 8,  desc: 0, mode: 0, err: 0, first: 100};
    tbl[2] = '{base: 0,    rows: 4, cols: 4,  desc: 0, mode: 1, err: 0, first: 0};
    tbl[3] = '{base: 0,    rows: 4, cols: 6,  desc: 0, mode: 0, err: 1, first: 0};
    tbl[4] = '{base: 4094, rows: 4, cols: 4,  desc: 0, mode: 0, err: 0, first: 4094};
    tbl[5] = '{base: 50,   rows: 8, cols: 12, desc: 1, mode: 2, err: 0, first: 53};
    tbl[6] = '{base: 0,    rows: 0, cols: 4,  desc: 0, mode: 0, err: 1, first: 0};
    tbl[7] = '{base: 0,    rows: 6, cols: 4,  desc: 0, mode: 0, err: 1, first: 0};
    tbl[8] = '{base: 0,    rows: 4, cols: 0,  desc: 0, mode: 0, err: 1, first: 0};
    tbl[9] = '{base: 10,   rows: 8, cols: 4,  desc: 0, mode: 1, err: 0, first: 10};

    rst_n = 1'b0; start = 1'b0; cfg_base = '0; cfg_rows = '0; cfg_cols = '0;
    cfg_desc = 1'b0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {40'd0, busy, done, cfg_err, rd_valid, tile_last, rd_addr, activate},
        64'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      run_pass(tbl[v].base, tbl[v].rows, tbl[v].cols, tbl[v].desc, tbl[v].mode,
               tbl[v].err, tbl[v].first);
      if (v == 0) begin
        chk("desc_b1", 64'(cap[1]), 64'd2);
        chk("desc_b4", 64'(cap[4]), 64'd7);
        chk("desc_b15", 64'(cap[15]), 64'd12);
      end
      if (v == 1) begin
        chk("c8_b3", 64'(cap[3]), 64'd103);
        chk("c8_b4", 64'(cap[4]), 64'd108);
        chk("c8_b7", 64'(cap[7]), 64'd111);
        chk("c8_b16", 64'(cap[16]), 64'd104);
      end
      if (v == 4) begin
        chk("wrap_b1", 64'(cap[1]), 64'd4095);
        chk("wrap_b2", 64'(cap[2]), 64'd0);
        chk("wrap_b3", 64'(cap[3]), 64'd1);
      end
    end

    // Abort mid-pass with reset while beat 5 is presented, then rerun from base.
    @(posedge clk); #1;
    start = 1'b1; cfg_base = 12'd20; cfg_rows = 16'd4; cfg_cols = 16'd4; cfg_desc = 1'b0;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_beat5", {51'd0, rd_valid, rd_addr}, {51'd0, 1'b1, 12'd24});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {40'd0, busy, done, cfg_err, rd_valid, tile_last, rd_addr, activate},
        64'd0);
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_no_done", {62'd0, done, busy}, 64'd0);
    rst_n = 1'b1;
    run_pass(20, 4, 4, 0, 0, 0, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
